sevenseg_scan_ctrl: RTL and testbench
=====================================

# sevenseg_scan_ctrl

Scan controller for the Boolean board's two 4-digit 7-segment displays, which share one cathode bus across 8 anodes. It time-multiplexes eight hex digits onto the shared anode and cathode pins and decodes each nibble to segments. Per-digit blanking suppresses ghosting. New display contents are double-buffered and applied only at frame boundaries, so the display never shows a torn frame. It sits between software-written display registers and the AN/CA..CG/DP pins.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- digit_data  in  32  eight hex nibbles; nibble i (bits 4i+3:4i) drives digit i.
- digit_en  in  8  per-digit enable; 0 means the digit stays dark for its whole slot.
- dp_in  in  8  per-digit decimal point; 1 means lit.
- load  in  1  single-cycle request to capture digit_data/digit_en/dp_in into the pending buffer.
- load_ack  out  1  one-cycle pulse when the pending contents become active.
- frame_done  out  1  one-cycle pulse when the digit 7 slot ends.
- an  out  8  anodes, active-low.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.

## Operation
- Reset values:
  - Outputs: an=8'hFF, seg=7'h7F, dp=1, load_ack=0, frame_done=0.
  - Internal: digit index 0, slot counter 0, active and pending buffers cleared (all digits disabled), pending-valid flag 0.
- FSM states:
  - BLANK: lasts BLANK_CYCLES. an=8'hFF, seg=7'h7F, dp=1.
  - DRIVE: lasts REFRESH_DIV−BLANK_CYCLES. an has only bit[idx] low if active en[idx]=1, otherwise an=8'hFF. seg is the decoded nibble and dp=~dp[idx].
  - Transitions: BLANK→DRIVE when its count expires. DRIVE→BLANK when its count expires, with idx incremented.
- Index wrap: idx runs 0..7 and wraps 7→0. The wrap cycle is the frame boundary.
- Hex decode, seg active-low {g..a}: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- load handling:
  - load copies the inputs into the pending buffer and sets pending-valid.
  - A second load before the next boundary overwrites the pending buffer (latest wins). Only one load_ack follows.
- At a frame boundary with pending-valid=1, the active buffer takes the pending contents, pending-valid clears, and load_ack pulses.
- load asserted on the boundary cycle itself: that cycle's input data is applied at this boundary and load_ack pulses. No stale pending data is used.
- Reset mid-frame: outputs go to reset values immediately (asynchronously). Scanning restarts at idx 0, and any pending load is discarded.

## Timing
- All outputs are registered. Pin state lags the internal FSM state by exactly 1 cycle.
- Slot length is exactly REFRESH_DIV cycles. Frame length is 8×REFRESH_DIV cycles. With default parameters the refresh rate is 125 Hz.
- frame_done and load_ack both pulse on the first output cycle of the new frame, which is the first BLANK cycle of digit 0.
- Changes to the load inputs never affect the pins before the next frame boundary.
- After reset deasserts, the first anode goes low at cycle BLANK_CYCLES+1.

## Configuration
- SEVSEG_GHOST_BLANK_EN defined: each slot uses the BLANK then DRIVE sequence described above.
- SEVSEG_GHOST_BLANK_EN undefined:
  - The BLANK state is not built, BLANK_CYCLES is ignored, and DRIVE lasts the full REFRESH_DIV.
  - Anodes switch directly from digit to digit, and the first anode goes low at cycle 1 after reset.
  - All other behaviour is identical.

## Test plan
All scenarios use REFRESH_DIV=16, BLANK_CYCLES=4, with SEVSEG_GHOST_BLANK_EN defined unless stated.
- Reset, then no load:
  - During reset: an=FF, seg=7F, dp=1.
  - After reset, an stays FF for all frames because all digits are disabled.
  - frame_done pulses every 128 cycles.
- Load data=32'h76543210, en=FF, dp=01 mid-frame:
  - Nothing changes until the boundary.
  - Next frame: digit0 shows an=FE, seg=1000000, dp=0. Digit1 shows an=FD, seg=1111001.
  - load_ack pulses once, coincident with frame_done.
- Blanking:
  - Each slot shows 4 cycles of an=FF followed by 12 cycles driven.
  - With the macro undefined, all 16 cycles are driven and there are no FF gaps between digits.
- Double load before the boundary (first data=FFFFFFFF, then data=AAAAAAAA):
  - The frame shows A (0001000) on all digits.
  - Exactly one load_ack pulse.
- Load on the boundary cycle with en=80, data=E0000000:
  - Only digit7 lights in the immediately following frame, with an=7F and seg=0000110.
  - load_ack pulses on that same boundary.
- Assert reset during digit 5 DRIVE with a load pending:
  - Outputs reach reset values immediately and no load_ack ever fires.
  - Scanning resumes at digit 0 with all digits disabled.

Source files
------------

// File: rtl/sevenseg_scan_ctrl_if.sv
// Pin and load bundle for sevenseg_scan_ctrl.
// master = register/software side, slave = scan controller.
interface sevenseg_scan_ctrl_if;
  logic [31:0] digit_data;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic        frame_done;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output digit_data, digit_en, dp_in, load,
    input  load_ack, frame_done, an, seg, dp
  );

  modport slave (
    input  digit_data, digit_en, dp_in, load,
    output load_ack, frame_done, an, seg, dp
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// 8-digit multiplexed 7-seg scanner with frame-aligned double buffering.
// Define SEVSEG_GHOST_BLANK_EN to add an all-off blank phase per slot.
module sevenseg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  sevenseg_scan_ctrl_if.slave disp
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

`ifdef SEVSEG_GHOST_BLANK_EN
  localparam int unsigned DRV_LEN = REFRESH_DIV - BLANK_CYCLES;
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
`else
  localparam int unsigned DRV_LEN = REFRESH_DIV;
`endif
  localparam logic [CW-1:0] DRV_LAST = CW'(DRV_LEN - 1);

  if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV) begin : g_cfg_err
    $error("sevenseg_scan_ctrl: bad REFRESH_DIV/BLANK_CYCLES");
  end

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          drive;
  logic          wrap;

`ifdef SEVSEG_GHOST_BLANK_EN
  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;
  state_e state_q, state_d;
`endif

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    wrap  = 1'b0;
`ifdef SEVSEG_GHOST_BLANK_EN
    state_d = state_q;
    drive   = (state_q == ST_DRIVE);
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRV_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          wrap    = (idx_q == 3'd7);
        end
      end
      default: state_d = ST_BLANK;
    endcase
`else
    drive = 1'b1;
    if (cnt_q == DRV_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
      wrap  = (idx_q == 3'd7);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef SEVSEG_GHOST_BLANK_EN
      state_q <= ST_BLANK;
`endif
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifdef SEVSEG_GHOST_BLANK_EN
      state_q <= state_d;
`endif
    end
  end

  logic [31:0] act_data_q, pnd_data_q;
  logic [7:0]  act_en_q, pnd_en_q;
  logic [7:0]  act_dp_q, pnd_dp_q;
  logic        pnd_vld_q;
  logic        wrap_q, ack_q;

  // A load on the wrap cycle bypasses the pending buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_data_q <= '0;
      act_en_q   <= '0;
      act_dp_q   <= '0;
      pnd_data_q <= '0;
      pnd_en_q   <= '0;
      pnd_dp_q   <= '0;
      pnd_vld_q  <= 1'b0;
      wrap_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      wrap_q <= wrap;
      ack_q  <= wrap & (disp.load | pnd_vld_q);
      if (wrap) begin
        pnd_vld_q <= 1'b0;
        if (disp.load) begin
          act_data_q <= disp.digit_data;
          act_en_q   <= disp.digit_en;
          act_dp_q   <= disp.dp_in;
        end else if (pnd_vld_q) begin
          act_data_q <= pnd_data_q;
          act_en_q   <= pnd_en_q;
          act_dp_q   <= pnd_dp_q;
        end
      end else if (disp.load) begin
        pnd_data_q <= disp.digit_data;
        pnd_en_q   <= disp.digit_en;
        pnd_dp_q   <= disp.dp_in;
        pnd_vld_q  <= 1'b1;
      end
    end
  end

  logic [3:0] nib;
  logic [7:0] an_d, an_q;
  logic [6:0] seg_d, seg_q;
  logic       dp_d, dp_q;
  logic       fd_q, la_q;

  assign nib = act_data_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (drive) begin
      if (act_en_q[idx_q]) an_d = ~(8'h01 << idx_q);
      seg_d = hex7(nib);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
      la_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= wrap_q;
      la_q  <= ack_q;
    end
  end

  assign disp.an         = an_q;
  assign disp.seg        = seg_q;
  assign disp.dp         = dp_q;
  assign disp.frame_done = fd_q;
  assign disp.load_ack   = la_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomised bench for sevenseg_scan_ctrl against a time-arithmetic model.
// Works with SEVSEG_GHOST_BLANK_EN defined or undefined.
module tb_sevenseg_scan_ctrl;
  localparam int R = 16;
`ifdef SEVSEG_GHOST_BLANK_EN
  localparam int BLK = 4;
`else
  localparam int BLK = 0;
`endif
  localparam int FRAME = 8 * R;

  logic clk = 1'b0;
  logic reset = 1'b1;
  sevenseg_scan_ctrl_if bus();

  sevenseg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .disp(bus)
  );

  always #5 clk = ~clk;

  int n, vec, miss;
  logic [31:0] m_data, p_data;
  logic [7:0]  m_en, m_dp, p_en, p_dp;
  bit          m_pv, m_ackflag;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_la, e_fd;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic string obs();
    return $sformatf("got an=%h seg=%b dp=%b ack=%b fd=%b want an=%h seg=%b dp=%b ack=%b fd=%b",
      bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done,
      e_an, e_seg, e_dp, e_la, e_fd);
  endfunction

  task automatic model_clear();
    m_data = '0; m_en = '0; m_dp = '0;
    p_data = '0; p_en = '0; p_dp = '0;
    m_pv = 0; m_ackflag = 0;
  endtask

  task automatic set_in(input logic ld, input logic [31:0] d,
                        input logic [7:0] e, input logic [7:0] p);
    bus.load = ld; bus.digit_data = d; bus.digit_en = e; bus.dp_in = p;
  endtask

  // One clock: expected pins after edge n show the scan position at n-1.
  task automatic tick();
    int s, idx, pos;
    @(posedge clk);
    n++;
    s = n - 1;
    idx = (s / R) % 8;
    pos = s % R;
    if (pos >= BLK) begin
      e_an  = m_en[idx] ? ~(8'h01 << idx) : 8'hFF;
      e_seg = hexseg(m_data[idx*4 +: 4]);
      e_dp  = ~m_dp[idx];
    end else begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end
    e_fd = (s > 0) && (s % FRAME == 0);
    e_la = m_ackflag;
    m_ackflag = 0;
    if (n % FRAME == 0) begin
      if (bus.load) begin
        m_data = bus.digit_data; m_en = bus.digit_en; m_dp = bus.dp_in;
        m_ackflag = 1;
      end else if (m_pv) begin
        m_data = p_data; m_en = p_en; m_dp = p_dp;
        m_ackflag = 1;
      end
      m_pv = 0;
    end else if (bus.load) begin
      p_data = bus.digit_data; p_en = bus.digit_en; p_dp = bus.dp_in;
      m_pv = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    set_in(0, '0, '0, '0);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      vec++;
      if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {8'hFF, 7'h7F, 3'b100}) begin
        miss++;
        $display("FAIL reset_hold got an=%h seg=%b dp=%b ack=%b fd=%b want an=ff seg=1111111 dp=1 ack=0 fd=0",
          bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done);
      end
    end
    reset = 1'b0;
    n = 0;
    model_clear();
  endtask

  task automatic test_idle();
    int fdc = 0;
    repeat (2 * FRAME + 4) begin
      tick();
      vec++;
      if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {e_an, e_seg, e_dp, e_la, e_fd}) begin
        miss++; $display("FAIL idle n=%0d %s", n, obs());
      end
      fdc += int'(bus.frame_done);
    end
    vec++;
    if (fdc !== 2) begin
      miss++; $display("FAIL idle_fd_count got %0d want 2", fdc);
    end
  endtask

  task automatic test_load_mid();
    int acks = 0, gaps = 0, stray = 0;
    int f;
    set_in(1, 32'h76543210, 8'hFF, 8'h01);
    tick();
    vec++;
    if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {e_an, e_seg, e_dp, e_la, e_fd}) begin
      miss++; $display("FAIL load_mid n=%0d %s", n, obs());
    end
    f = (n / FRAME) + 1;
    while (n < (f + 1) * FRAME + 2) begin
      set_in(0, $urandom, 8'($urandom), 8'($urandom));
      tick();
      vec++;
      if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {e_an, e_seg, e_dp, e_la, e_fd}) begin
        miss++; $display("FAIL load_mid n=%0d %s", n, obs());
      end
      acks += int'(bus.load_ack);
      if (bus.load_ack && !bus.frame_done) stray++;
      if (n > f * FRAME + 1 && n <= (f + 1) * FRAME + 1 && bus.an == 8'hFF) gaps++;
    end
    vec++;
    if (acks !== 1 || stray !== 0) begin
      miss++; $display("FAIL load_mid_ack got acks=%0d stray=%0d want acks=1 stray=0", acks, stray);
    end
    vec++;
    if (gaps !== 8 * BLK) begin
      miss++; $display("FAIL blank_gaps got %0d want %0d", gaps, 8 * BLK);
    end
  endtask

  task automatic test_double_load();
    int acks = 0, aseg = 0;
    int f;
    set_in(1, 32'hFFFFFFFF, 8'hFF, 8'h00);
    tick();
    set_in(0, $urandom, 8'hFF, 8'h00);
    repeat (10) tick();
    set_in(1, 32'hAAAAAAAA, 8'hFF, 8'h00);
    tick();
    set_in(0, 32'h0, 8'h00, 8'h00);
    f = (n / FRAME) + 1;
    while (n < (f + 1) * FRAME + 2) begin
      tick();
      vec++;
      if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {e_an, e_seg, e_dp, e_la, e_fd}) begin
        miss++; $display("FAIL double_load n=%0d %s", n, obs());
      end
      acks += int'(bus.load_ack);
      if (n > f * FRAME + 1 && n <= (f + 1) * FRAME + 1 && bus.an != 8'hFF && bus.seg == 7'b0001000) aseg++;
    end
    vec++;
    if (acks !== 1) begin
      miss++; $display("FAIL double_load_ack got %0d want 1", acks);
    end
    vec++;
    if (aseg !== 8 * (R - BLK)) begin
      miss++; $display("FAIL double_load_A got %0d want %0d", aseg, 8 * (R - BLK));
    end
  endtask

  task automatic test_boundary_load();
    int acks = 0, lit = 0;
    int f;
    set_in(0, '0, '0, '0);
    while (n % FRAME != FRAME - 1) tick();
    set_in(1, 32'hE0000000, 8'h80, 8'h00);
    tick();
    set_in(0, $urandom, 8'hFF, 8'hFF);
    f = n / FRAME;
    repeat (FRAME + 2) begin
      tick();
      vec++;
      if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {e_an, e_seg, e_dp, e_la, e_fd}) begin
        miss++; $display("FAIL boundary_load n=%0d %s", n, obs());
      end
      if (n == f * FRAME + 1 && bus.load_ack !== 1'b1) begin
        miss++; $display("FAIL boundary_ack_time n=%0d got 0 want 1", n);
      end
      acks += int'(bus.load_ack);
      if (bus.an == 8'h7F && bus.seg == 7'b0000110) lit++;
    end
    vec++;
    if (acks !== 1 || lit !== R - BLK) begin
      miss++; $display("FAIL boundary_load_sum got acks=%0d lit=%0d want acks=1 lit=%0d", acks, lit, R - BLK);
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    while (n % FRAME != 20) tick();
    set_in(1, $urandom, 8'hFF, 8'($urandom));
    tick();
    set_in(0, '0, '0, '0);
    while (!(((n - 1) % FRAME) / R == 5 && ((n - 1) % R) >= BLK + 2)) tick();
    #2;
    reset = 1'b1;
    #1;
    vec++;
    if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {8'hFF, 7'h7F, 3'b100}) begin
      miss++;
      $display("FAIL reset_async got an=%h seg=%b dp=%b ack=%b fd=%b want an=ff seg=1111111 dp=1 ack=0 fd=0",
        bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    model_clear();
    repeat (2 * FRAME + 4) begin
      tick();
      vec++;
      if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {e_an, e_seg, e_dp, e_la, e_fd}) begin
        miss++; $display("FAIL reset_mid n=%0d %s", n, obs());
      end
      acks += int'(bus.load_ack);
    end
    vec++;
    if (acks !== 0) begin
      miss++; $display("FAIL reset_mid_ack got %0d want 0", acks);
    end
  endtask

  task automatic test_random();
    logic ld;
    repeat (6 * FRAME) begin
      if (n % FRAME == FRAME - 1) ld = 1'($urandom_range(0, 1));
      else ld = ($urandom_range(0, 39) == 0);
      set_in(ld, $urandom, 8'($urandom), 8'($urandom));
      tick();
      vec++;
      if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {e_an, e_seg, e_dp, e_la, e_fd}) begin
        miss++; $display("FAIL random n=%0d %s", n, obs());
      end
    end
    set_in(0, '0, '0, '0);
  endtask

  initial begin
    vec = 0; miss = 0; n = 0;
    model_clear();
    test_reset();
    test_idle();
    test_load_mid();
    test_double_load();
    test_boundary_load();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
